// File: rtl/imm_ext_pkg.sv
// Shared definitions for the ID->EX immediate-extension stage: mode encoding
// and instruction bit-field positions.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    IMM_ZE12 = 3'd0,
    IMM_SE9  = 3'd1,
    IMM_SE19 = 3'd2,
    IMM_SE26 = 3'd3,
    IMM_MOVZ = 3'd4,
    IMM_BR26 = 3'd5,
    IMM_CB19 = 3'd6,
    IMM_RSVD = 3'd7
  } imm_mode_t;

  localparam int ZE12_LSB    = 10;
  localparam int ZE12_MSB    = 21;
  localparam int SE9_LSB     = 12;
  localparam int SE9_MSB     = 20;
  localparam int SE19_LSB    = 5;
  localparam int SE19_MSB    = 23;
  localparam int SE26_LSB    = 0;
  localparam int SE26_MSB    = 25;
  localparam int MOVZ_IMM_LSB = 5;
  localparam int MOVZ_IMM_MSB = 20;
  localparam int MOVZ_HW_LSB  = 21;
  localparam int MOVZ_HW_MSB  = 22;

  // Highest instruction bit any format reads; bits above it are ignored.
  localparam int INSTR_USED_MSB = 25;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate extractor: instruction word + mode -> DATA_W-bit
// immediate and an error flag (reserved mode or MOVZ shift past DATA_W).
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       instr,
  input  logic [2:0]        mode,
  output logic [DATA_W-1:0] imm,
  output logic              err
);

  logic signed [DATA_W-1:0] se9;
  logic signed [DATA_W-1:0] se19;
  logic signed [DATA_W-1:0] se26;
  logic        [DATA_W-1:0] ze12;
  logic        [DATA_W-1:0] movz;
  logic        [1:0]        hw;
  logic        [7:0]        movz_top;
  logic                     movz_err;
  logic                     unused_hi;

  assign unused_hi = ^instr[31:INSTR_USED_MSB+1];

  assign ze12 = {{(DATA_W-12){1'b0}}, instr[ZE12_MSB:ZE12_LSB]};
  assign se9  = {{(DATA_W-9){instr[SE9_MSB]}}, instr[SE9_MSB:SE9_LSB]};
  assign se19 = {{(DATA_W-19){instr[SE19_MSB]}}, instr[SE19_MSB:SE19_LSB]};
  assign se26 = {{(DATA_W-26){instr[SE26_MSB]}}, instr[SE26_MSB:SE26_LSB]};

  // Shift amounts >= DATA_W fall off the top and leave zero, which is the
  // "keep the bits that fit" behaviour for an out-of-range halfword.
  assign hw       = instr[MOVZ_HW_MSB:MOVZ_HW_LSB];
  assign movz     = {{(DATA_W-16){1'b0}}, instr[MOVZ_IMM_MSB:MOVZ_IMM_LSB]} << {hw, 4'b0000};
  assign movz_top = {2'b00, hw, 4'b0000} + 8'd16;
  assign movz_err = (32'(movz_top) > DATA_W);

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (imm_mode_t'(mode))
      IMM_ZE12: imm = ze12;
      IMM_SE9:  imm = se9;
      IMM_SE19: imm = se19;
      IMM_SE26: imm = se26;
      IMM_MOVZ: begin
        imm = movz;
        err = movz_err;
      end
      IMM_BR26: imm = se26 <<< 2;
      IMM_CB19: imm = se19 <<< 2;
      IMM_RSVD: begin
        imm = '0;
        err = 1'b1;
      end
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage at the ID->EX boundary: one valid/ready
// register with flush, plus a saturating count of accepted immediates.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [2:0]        mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic              err_out,
  output logic [CNT_W-1:0]  acc_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] imm_p0;
  logic              err_p0;
  logic [DATA_W-1:0] imm_p1;
  logic              err_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  cnt;
  logic              accept;

  imm_ext_comb #(.DATA_W(DATA_W)) u_comb (
    .instr (instr),
    .mode  (mode),
    .imm   (imm_p0),
    .err   (err_p0)
  );

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // p0 -> p1: capture on accept; flush wins over both accept and hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      imm_p1 <= '0;
      err_p1 <= 1'b0;
      cnt    <= '0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (accept)    vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;

      if (accept) begin
        imm_p1 <= imm_p0;
        err_p1 <= err_p0;
        cnt    <= sat_inc(cnt);
      end
    end
  end

  assign out_valid = vld_p1;
  assign imm_out   = imm_p1;
  assign err_out   = err_p1;
  assign acc_count = cnt;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: 64-bit, 32-bit and 2-bit-counter
// instances share the same stimulus.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  mode;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_err;
  logic [63:0] a_imm;
  logic [15:0] a_cnt;
  logic        b_in_ready, b_out_valid, b_err;
  logic [31:0] b_imm;
  logic [15:0] b_cnt;
  logic        c_in_ready, c_out_valid, c_err;
  logic [63:0] c_imm;
  logic [1:0]  c_cnt;

  always #5 clk = ~clk;

  imm_extend_stage #(.DATA_W(64), .CNT_W(16)) u64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .mode(mode), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .imm_out(a_imm), .err_out(a_err), .acc_count(a_cnt));

  imm_extend_stage #(.DATA_W(32), .CNT_W(16)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .mode(mode), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .imm_out(b_imm), .err_out(b_err), .acc_count(b_cnt));

  imm_extend_stage #(.DATA_W(64), .CNT_W(2)) uc2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .instr(instr), .mode(mode), .flush(flush), .out_valid(c_out_valid),
    .out_ready(out_ready), .imm_out(c_imm), .err_out(c_err), .acc_count(c_cnt));

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] instr;
    logic [63:0] e64;
    logic        err64;
    logic [31:0] e32;
    logic        err32;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h003F_FC00, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
    vecs[1]  = '{3'd1, 32'h0010_0000, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0};
    vecs[2]  = '{3'd1, 32'h000F_F000, 64'h0000_0000_0000_00FF, 1'b0, 32'h0000_00FF, 1'b0};
    vecs[3]  = '{3'd2, 32'h0080_0000, 64'hFFFF_FFFF_FFFC_0000, 1'b0, 32'hFFFC_0000, 1'b0};
    vecs[4]  = '{3'd3, 32'h03FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{3'd5, 32'h03FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[6]  = '{3'd5, 32'h01FF_FFFF, 64'h0000_0000_07FF_FFFC, 1'b0, 32'h07FF_FFFC, 1'b0};
    vecs[7]  = '{3'd6, 32'h00FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[8]  = '{3'd6, 32'h0000_0020, 64'h0000_0000_0000_0004, 1'b0, 32'h0000_0004, 1'b0};
    vecs[9]  = '{3'd4, 32'h0077_DDE0, 64'hBEEF_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[10] = '{3'd4, 32'h0037_DDE0, 64'h0000_0000_BEEF_0000, 1'b0, 32'hBEEF_0000, 1'b0};
    vecs[11] = '{3'd4, 32'h0057_DDE0, 64'h0000_BEEF_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'd7, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[13] = '{3'd0, 32'hFFFF_FFFF, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; instr = '0; mode = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_imm", a_imm, 0);
    chk("rst_err", a_err, 0);
    chk("rst_cnt", a_cnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // Back-to-back stream; each vector's result appears one edge later.
    for (int i = 0; i < NV; i++) begin
      mode = vecs[i].mode; instr = vecs[i].instr; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), a_out_valid, 1);
      chk($sformatf("v%0d_imm64", i), a_imm, vecs[i].e64);
      chk($sformatf("v%0d_err64", i), a_err, vecs[i].err64);
      chk($sformatf("v%0d_imm32", i), b_imm, vecs[i].e32);
      chk($sformatf("v%0d_err32", i), b_err, vecs[i].err32);
      chk($sformatf("v%0d_cnt", i), a_cnt, i + 1);
      if (i < 5) chk($sformatf("v%0d_satcnt", i), c_cnt, (i < 2) ? i + 1 : 3);
    end

    // Hold: downstream stalls, new input waiting must not be taken.
    out_ready = 1'b0; mode = 3'd0; instr = 32'h0015_5400;
    #1;
    chk("hold_in_ready", a_in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", k), a_out_valid, 1);
      chk($sformatf("hold%0d_imm", k), a_imm, vecs[NV-1].e64);
      chk($sformatf("hold%0d_in_ready", k), a_in_ready, 0);
    end
    chk("hold_cnt", a_cnt, NV);

    // Release with a different word: drain and refill in one edge.
    out_ready = 1'b1; instr = 32'h0004_8C00;
    #1;
    chk("release_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    chk("replace_valid", a_out_valid, 1);
    chk("replace_imm", a_imm, 64'h123);
    chk("replace_cnt", a_cnt, NV + 1);

    // Flush during hold with a pending input.
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; instr = 32'h001D_DC00;
    @(posedge clk); #1;
    chk("flush_valid", a_out_valid, 0);
    chk("flush_cnt", a_cnt, NV + 1);
    chk("flush_satcnt", c_cnt, 3);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    chk("flush_stays_empty", a_out_valid, 0);

    // Single accept then drain.
    in_valid = 1'b1; out_ready = 1'b1; mode = 3'd0; instr = 32'h0000_2800;
    @(posedge clk); #1;
    chk("single_valid", a_out_valid, 1);
    chk("single_imm", a_imm, 64'hA);
    chk("single_cnt", a_cnt, NV + 2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", a_out_valid, 0);

    // Asynchronous reset while an entry is held.
    in_valid = 1'b1; out_ready = 1'b0; instr = 32'h003F_FC00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("prerst_valid", a_out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_imm", a_imm, 0);
    chk("midrst_err", b_err, 0);
    chk("midrst_cnt", a_cnt, 0);
    chk("midrst_imm32", b_imm, 0);
    chk("midrst_satcnt", c_cnt, 0);
    chk("midrst_c_valid", c_out_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("final_in_ready", a_in_ready, 1);
    chk("final_b_ready", b_in_ready & c_in_ready, 1);
    chk("final_b_valid", b_out_valid, 0);
    chk("final_c_err", c_err, 0);
    chk("final_b_cnt", b_cnt, 0);
    chk("final_c_imm", c_imm, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
